uart_time_frame_ctrl: RTL



---
 rtl/uart_clock_pkg.sv | 30 +++
 rtl/bcd_time_check.sv | 15 +
 rtl/uart_time_frame_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_clock_pkg.sv
// Shared types and constants for the UART-settable clock: FSM states, error codes,
// default frame bytes and a BCD field range helper.
package uart_clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOT_HDR0,
    GET_H,
    GET_M,
    GET_S,
    GET_T,
    LOAD
  } state_t;

  localparam logic [1:0] ERR_HDR     = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TAIL    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_HDR0 = 8'hFF;
  localparam logic [7:0] DEF_HDR1 = 8'hA5;
  localparam logic [7:0] DEF_TAIL = 8'hF0;

  // Both nibbles must be decimal digits; once they are, a plain byte compare
  // against a BCD limit orders the same way as the decimal values.
  function automatic logic bcd_field_ok(input logic [7:0] b, input logic [7:0] max_bcd);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max_bcd);
  endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of a BCD hh:mm:ss triple (hour 00-23, min/sec 00-59).
module bcd_time_check
  import uart_clock_pkg::*;
(
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  output logic       ok
);

  assign ok = bcd_field_ok(hour, 8'h23) &&
              bcd_field_ok(min,  8'h59) &&
              bcd_field_ok(sec,  8'h59);

endmodule

// File: rtl/uart_time_frame_ctrl.sv
// Set-time frame parser (FF A5 HH MM SS F0) feeding the clock counter over a load handshake.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_time_frame_ctrl
  import uart_clock_pkg::*;
#(
  parameter logic [7:0] HDR0        = DEF_HDR0,
  parameter logic [7:0] HDR1        = DEF_HDR1,
  parameter logic [7:0] TAIL        = DEF_TAIL,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter int         TO_W        = 21
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Done,
  input  logic       Load_Ready,
  output logic       Load_Valid,
  output logic [7:0] Load_Hour,
  output logic [7:0] Load_Min,
  output logic [7:0] Load_Sec,
  output logic       Frame_Err,
  output logic [1:0] Err_Code,
  output logic       Busy
);

  // Load handshake: Load_Valid is high throughout LOAD and Load_* stay stable;
  // a transfer happens on any cycle with Load_Valid & Load_Ready, after which
  // the controller is back in IDLE with Load_Valid low.

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYC");
  end

  state_t     state, state_d;
  logic [7:0] hour_sh, min_sh, sec_sh;
  logic       err_d;
  logic [1:0] code_d;
  logic       load_en;
  logic       time_ok;
  logic       timeout_hit;

  bcd_time_check u_check (
    .hour (hour_sh),
    .min  (min_sh),
    .sec  (sec_sh),
    .ok   (time_ok)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || Rx_Done || state == IDLE || state == LOAD) to_cnt <= '0;
    else                                                    to_cnt <= to_cnt + 1'b1;
  end

  // A byte arriving on the terminal count wins over the timeout.
  assign timeout_hit = !Rx_Done && state != IDLE && state != LOAD &&
                       to_cnt == TO_W'(TIMEOUT_CYC - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    code_d  = Err_Code;
    load_en = 1'b0;
    unique case (state)
      IDLE: if (Rx_Done && Rx_Data == HDR0) state_d = GOT_HDR0;
      GOT_HDR0: begin
        if (Rx_Done) begin
          if (Rx_Data == HDR1) begin
            state_d = GET_H;
          end else if (Rx_Data != HDR0) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = ERR_HDR;
          end
        end
      end
      GET_H: if (Rx_Done) state_d = GET_M;
      GET_M: if (Rx_Done) state_d = GET_S;
      GET_S: if (Rx_Done) state_d = GET_T;
      GET_T: begin
        if (Rx_Done) begin
          state_d = IDLE;
          if (Rx_Data != TAIL) begin
            err_d  = 1'b1;
            code_d = ERR_TAIL;
          end else if (!time_ok) begin
            err_d  = 1'b1;
            code_d = ERR_RANGE;
          end else begin
            load_en = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: if (Load_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hour_sh   <= 8'h00;
      min_sh    <= 8'h00;
      sec_sh    <= 8'h00;
      Load_Hour <= 8'h00;
      Load_Min  <= 8'h00;
      Load_Sec  <= 8'h00;
      Frame_Err <= 1'b0;
      Err_Code  <= ERR_HDR;
    end else begin
      if (Rx_Done) begin
        case (state)
          GET_H:   hour_sh <= Rx_Data;
          GET_M:   min_sh  <= Rx_Data;
          GET_S:   sec_sh  <= Rx_Data;
          default: ;
        endcase
      end
      if (load_en) begin
        Load_Hour <= hour_sh;
        Load_Min  <= min_sh;
        Load_Sec  <= sec_sh;
      end
      Frame_Err <= err_d;
      Err_Code  <= code_d;
    end
  end

  assign Load_Valid = (state == LOAD);
  assign Busy       = (state != IDLE);

endmodule
